// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives synchronous imem and
// delivers a 2-cycle fetched instruction stream to the controller.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   load_pc        1 = advance, 0 = stall (hold everything)
//   sel_pc         00 pc+4, 01 start_pc, 10 branch_target, 11 reg_target
//   start_pc       restart address
//   branch_target  datapath branch address
//   reg_target     register-sourced target
//   imem_addr      imem word address (issue address [ADDR_W+1:2])
//   imem_en        imem read enable (= load_pc)
//   imem_rdata     imem data, valid one cycle after an enabled address
//   instr_out      instruction to controller
//   instr_valid    instr_out is a real, non-squashed instruction
//   instr_pc       byte PC of instr_out
//   misalign_err   sticky: a redirect target had bits[1:0] != 0
module instr_fetch_stage #(
    parameter int          ADDR_W    = 11,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_pc,
    input  logic [1:0]        sel_pc,
    input  logic [31:0]       start_pc,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       reg_target,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    output logic [31:0]       instr_pc,
    output logic              misalign_err
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } s1_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } s2_t;

    logic [31:0] pc;
    s1_t         s1;
    s2_t         s2;

    logic [31:0] raw_fa;
    logic [31:0] fa;
    logic        redirect;

    always_comb begin
        raw_fa = pc;
        unique case (sel_pc)
            2'b00: raw_fa = pc;
            2'b01: raw_fa = start_pc;
            2'b10: raw_fa = branch_target;
            2'b11: raw_fa = reg_target;
        endcase
    end

    assign fa        = {raw_fa[31:2], 2'b00};
    assign redirect  = load_pc & (sel_pc != 2'b00);
    assign imem_addr = fa[ADDR_W+1:2];
    assign imem_en   = load_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            s1 <= '0;
        end else if (load_pc) begin
            pc       <= fa + 32'd4;
            s1.valid <= 1'b1;
            s1.pc    <= fa;
        end
    end

    // A redirect squashes the entry moving s1->s2: it was fetched from
    // the wrong path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2.valid <= 1'b0;
            s2.pc    <= '0;
            s2.instr <= NOP_INSTR;
        end else if (load_pc) begin
            s2.pc <= s1.pc;
            if (redirect || !s1.valid) begin
                s2.valid <= 1'b0;
                s2.instr <= NOP_INSTR;
            end else begin
                s2.valid <= 1'b1;
                s2.instr <= imem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (redirect && raw_fa[1:0] != 2'b00) begin
            misalign_err <= 1'b1;
        end
    end

    assign instr_out   = s2.instr;
    assign instr_valid = s2.valid;
    assign instr_pc    = s2.pc;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a synchronous imem model
// whose word n holds 0xA000_0000 + n.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_pc;
    logic [1:0]  sel_pc;
    logic [31:0] start_pc;
    logic [31:0] branch_target;
    logic [31:0] reg_target;
    logic [10:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    instr_fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_pc      (load_pc),
        .sel_pc       (sel_pc),
        .start_pc     (start_pc),
        .branch_target(branch_target),
        .reg_target   (reg_target),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .instr_pc     (instr_pc),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_en)
            imem_rdata <= 32'hA000_0000 + {21'd0, imem_addr};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic out(input string tag,
                       input logic        v,
                       input logic [31:0] p,
                       input logic [31:0] i);
        chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
        chk({tag, ".pc"}, instr_pc, p);
        chk({tag, ".instr"}, instr_out, i);
    endtask

    initial begin
        rst_n         = 1'b0;
        load_pc       = 1'b0;
        sel_pc        = 2'b00;
        start_pc      = 32'h0;
        branch_target = 32'h0;
        reg_target    = 32'h0;
        step();
        step();
        out("rst", 1'b0, 32'h0, NOP);
        chk("rst.err", {31'd0, misalign_err}, 32'd0);
        chk("rst.addr", {21'd0, imem_addr}, 32'h0);
        chk("rst.en", {31'd0, imem_en}, 32'd0);

        // start via sel_pc=01
        rst_n    = 1'b1;
        load_pc  = 1'b1;
        sel_pc   = 2'b01;
        start_pc = 32'h100;
        step();
        sel_pc = 2'b00;
        out("start.c1", 1'b0, 32'h0, NOP);
        step();
        out("start.c2", 1'b1, 32'h100, 32'hA000_0040);
        step();
        out("seq.c3", 1'b1, 32'h104, 32'hA000_0041);
        step();
        out("seq.c4", 1'b1, 32'h108, 32'hA000_0042);

        // stall 3 cycles
        load_pc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            out("stall", 1'b1, 32'h108, 32'hA000_0042);
            chk("stall.addr", {21'd0, imem_addr}, 32'h44);
            chk("stall.en", {31'd0, imem_en}, 32'd0);
        end
        load_pc = 1'b1;
        step();
        out("resume.1", 1'b1, 32'h10C, 32'hA000_0043);
        step();
        out("resume.2", 1'b1, 32'h110, 32'hA000_0044);

        // get running at 0x200
        sel_pc        = 2'b10;
        branch_target = 32'h200;
        step();
        sel_pc = 2'b00;
        out("to200.sq", 1'b0, 32'h114, NOP);
        step();
        out("to200", 1'b1, 32'h200, 32'hA000_0080);

        // branch to 0x400
        sel_pc        = 2'b10;
        branch_target = 32'h400;
        step();
        sel_pc = 2'b00;
        chk("br.sq.valid", {31'd0, instr_valid}, 32'd0);
        chk("br.sq.instr", instr_out, NOP);
        step();
        out("br.tgt", 1'b1, 32'h400, 32'hA000_0100);
        step();
        out("br.tgt4", 1'b1, 32'h404, 32'hA000_0101);

        // misaligned register target
        sel_pc     = 2'b11;
        reg_target = 32'h302;
        #1;
        chk("mis.addr", {21'd0, imem_addr}, 32'hC0);
        chk("mis.pre", {31'd0, misalign_err}, 32'd0);
        step();
        sel_pc = 2'b00;
        chk("mis.set", {31'd0, misalign_err}, 32'd1);
        chk("mis.sq", {31'd0, instr_valid}, 32'd0);
        step();
        out("mis.tgt", 1'b1, 32'h300, 32'hA000_00C0);
        chk("mis.hold", {31'd0, misalign_err}, 32'd1);

        // redirect request during stall is ignored
        load_pc       = 1'b0;
        sel_pc        = 2'b10;
        branch_target = 32'h500;
        step();
        step();
        out("stallbr", 1'b1, 32'h300, 32'hA000_00C0);
        load_pc = 1'b1;
        sel_pc  = 2'b00;
        step();
        out("stallbr.rel", 1'b1, 32'h304, 32'hA000_00C1);
        sel_pc = 2'b10;
        step();
        sel_pc = 2'b00;
        chk("br2.sq", {31'd0, instr_valid}, 32'd0);
        step();
        out("br2.tgt", 1'b1, 32'h500, 32'hA000_0140);
        chk("mis.hold2", {31'd0, misalign_err}, 32'd1);

        // reset one cycle after a redirect
        sel_pc        = 2'b10;
        branch_target = 32'h600;
        step();
        sel_pc = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        out("arst", 1'b0, 32'h0, NOP);
        chk("arst.err", {31'd0, misalign_err}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rel.c1", {31'd0, instr_valid}, 32'd0);
        step();
        out("rel.c2", 1'b1, 32'h0, 32'hA000_0000);

        // wrap-around at top of address space
        sel_pc        = 2'b10;
        branch_target = 32'hFFFF_FFF8;
        step();
        sel_pc = 2'b00;
        step();
        out("wrap.f8", 1'b1, 32'hFFFF_FFF8, 32'hA000_07FE);
        step();
        out("wrap.fc", 1'b1, 32'hFFFF_FFFC, 32'hA000_07FF);
        step();
        out("wrap.0", 1'b1, 32'h0, 32'hA000_0000);
        chk("wrap.err", {31'd0, misalign_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
